countdown_timer_bank: RTL and testbench

COUNTDOWN_TIMER_BANK -- requirements
Module: countdown_timer_bank

---
 rtl/countdown_timer_bank.sv | 107 ++++++++++
 tb/tb_countdown_timer_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_bank.sv
// countdown_timer_bank: bank of independent countdown timers with one-shot/auto-reload and sticky expiry
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   load         per-channel load strobe (wins over start and over a same-cycle tick)
//   load_value   per-channel start value, channel i at [i*WIDTH +: WIDTH]
//   start        per-channel run/pause toggle strobe
//   reload_mode  per-channel mode: 1 = auto-reload, 0 = one-shot
//   count_out    per-channel current count, same packing as load_value
//   running      per-channel run flag
//   done_pulse   one-cycle pulse following each expiry
//   expired      sticky expiry flag, cleared only by load or reset
//
// Configuration:
//   TIMER_PRESCALE_EN  when defined, a shared free-running prescaler produces one tick
//                      every PRESCALE clk cycles; otherwise every clk cycle is a tick.
module countdown_timer_bank #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 50000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       reload_mode,
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       done_pulse,
    output logic [CHANNELS-1:0]       expired
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

    logic tick;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre;

    assign tick = (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre <= '0;
        else
            pre <= tick ? '0 : pre + PW'(1);
    end
`else
    assign tick = 1'b1;
`endif

    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] reload;
        logic [WIDTH-1:0] lv;
        logic [WIDTH-1:0] count_nxt;
        logic             run;
        logic             expd;
        logic             done;
        logic             fire;

        assign lv = load_value[i*WIDTH +: WIDTH];

        // Expiry happens only on the 1 -> 0 step, so a count parked at 0 never re-fires.
        assign fire = tick && run && (count == WIDTH'(1));

        always_comb begin
            count_nxt = fire                                 ? (reload_mode[i] ? reload : '0) :
                        (tick && run && count != WIDTH'(0))  ? count - WIDTH'(1) :
                                                               count;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count  <= '0;
                reload <= '0;
                run    <= 1'b0;
                done   <= 1'b0;
                expd   <= 1'b0;
            end else if (load[i]) begin
                count  <= lv;
                reload <= lv;
                run    <= 1'b0;
                done   <= 1'b0;
                expd   <= (lv == '0);
            end else begin
                count  <= count_nxt;
                run    <= run ^ start[i];
                done   <= fire;
                expd   <= expd | fire;
            end
        end

        assign count_out[i*WIDTH +: WIDTH] = count;
        assign running[i]                  = run;
        assign done_pulse[i]               = done;
        assign expired[i]                  = expd;
    end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// tb_countdown_timer_bank: directed and randomized checks of countdown_timer_bank against a cycle model
module tb_countdown_timer_bank;
    localparam int WIDTH    = 10;
    localparam int CHANNELS = 2;
    localparam int PRESCALE = 4;
`ifdef TIMER_PRESCALE_EN
    localparam int TK = PRESCALE;
`else
    localparam int TK = 1;
`endif

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [CHANNELS-1:0]       load = '0;
    logic [CHANNELS*WIDTH-1:0] load_value = '0;
    logic [CHANNELS-1:0]       start = '0;
    logic [CHANNELS-1:0]       reload_mode = '0;
    logic [CHANNELS*WIDTH-1:0] count_out;
    logic [CHANNELS-1:0]       running;
    logic [CHANNELS-1:0]       done_pulse;
    logic [CHANNELS-1:0]       expired;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt  [CHANNELS];
    int m_rel  [CHANNELS];
    bit m_run  [CHANNELS];
    bit m_done [CHANNELS];
    bit m_exp  [CHANNELS];
    int m_pre;
    int pulses [CHANNELS];

    countdown_timer_bank #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_value(load_value),
        .start(start),
        .reload_mode(reload_mode),
        .count_out(count_out),
        .running(running),
        .done_pulse(done_pulse),
        .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_cnt[c] = 0; m_rel[c] = 0; m_run[c] = 0; m_done[c] = 0; m_exp[c] = 0;
        end
        m_pre = 0;
    endtask

    // One rising edge of the reference: a timer counts whole ticks down from its value,
    // expiring when it reaches zero from one.
    task automatic model_edge();
        bit tk;
        int lv;
        tk = 1'b1;
`ifdef TIMER_PRESCALE_EN
        tk = (m_pre == PRESCALE - 1);
        m_pre = tk ? 0 : m_pre + 1;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            lv = int'(load_value[c*WIDTH +: WIDTH]);
            if (load[c]) begin
                m_cnt[c] = lv; m_rel[c] = lv; m_run[c] = 0; m_done[c] = 0; m_exp[c] = (lv == 0);
            end else begin
                m_done[c] = 0;
                if (tk && m_run[c] && m_cnt[c] > 0) begin
                    m_cnt[c] = m_cnt[c] - 1;
                    if (m_cnt[c] == 0) begin
                        if (reload_mode[c]) m_cnt[c] = m_rel[c];
                        m_exp[c] = 1;
                        m_done[c] = 1;
                    end
                end
                if (start[c]) m_run[c] = !m_run[c];
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CHANNELS; c++) begin
            chk($sformatf("count[%0d]", c), 64'(count_out[c*WIDTH +: WIDTH]), 64'(m_cnt[c]));
            chk($sformatf("running[%0d]", c), 64'(running[c]), 64'(m_run[c]));
            chk($sformatf("done_pulse[%0d]", c), 64'(done_pulse[c]), 64'(m_done[c]));
            chk($sformatf("expired[%0d]", c), 64'(expired[c]), 64'(m_exp[c]));
            if (done_pulse[c]) pulses[c]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_load(input int c, input int v);
        load[c] = 1'b1;
        load_value[c*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic clear_strobes();
        load  = '0;
        start = '0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Single long one-shot count on channel 0.
        set_load(0, 300);
        step();
        clear_strobes();
        start[0] = 1'b1;
        step();
        clear_strobes();
        pulses[0] = 0;
        repeat (320 * TK) step();
        chk("oneshot_pulses", 64'(pulses[0]), 64'd1);
        chk("oneshot_hold", 64'(count_out[0 +: WIDTH]), 64'd0);
        chk("oneshot_expired", 64'(expired[0]), 64'd1);

        // Auto-reload period of 4 on channel 1.
        reload_mode[1] = 1'b1;
        set_load(1, 4);
        step();
        clear_strobes();
        start[1] = 1'b1;
        step();
        clear_strobes();
        pulses[1] = 0;
        repeat (20 * TK) step();
        chk("reload_pulses", 64'(pulses[1]), 64'd5);
        chk("reload_running", 64'(running[1]), 64'd1);
        reload_mode[1] = 1'b0;

        // Pause and resume on channel 0.
        set_load(0, 10);
        step();
        clear_strobes();
        start[0] = 1'b1;
        step();
        clear_strobes();
        pulses[0] = 0;
        repeat (2 * TK) step();
        start[0] = 1'b1;
        step();
        clear_strobes();
        repeat (5 * TK) step();
        chk("pause_running", 64'(running[0]), 64'd0);
        start[0] = 1'b1;
        step();
        clear_strobes();
        repeat (10 * TK) step();
        chk("pause_pulses", 64'(pulses[0]), 64'd1);

        // Load wins over start; load of zero expires at once with no pulse.
        set_load(0, 5);
        start[0] = 1'b1;
        set_load(1, 0);
        step();
        clear_strobes();
        chk("ls_count", 64'(count_out[0 +: WIDTH]), 64'd5);
        chk("ls_running", 64'(running[0]), 64'd0);
        chk("zero_expired", 64'(expired[1]), 64'd1);
        chk("zero_done", 64'(done_pulse[1]), 64'd0);

        // Asynchronous reset between edges mid-count.
        set_load(0, 300);
        step();
        clear_strobes();
        start[0] = 1'b1;
        step();
        clear_strobes();
        repeat (150) step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_count", 64'(count_out), 64'd0);
        @(negedge clk);
        compare_all();
        reset = 1'b1;
        pulses[0] = 0;
        pulses[1] = 0;
        repeat (20) step();
        chk("post_reset_pulses", 64'(pulses[0] + pulses[1]), 64'd0);

        // Randomized traffic on all channels.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                load[c]  = ($urandom_range(0, 15) == 0);
                start[c] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 19) == 0) reload_mode[c] = ~reload_mode[c];
                load_value[c*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) :
                                                                            WIDTH'($urandom_range(0, 8));
            end
            step();
        end
        clear_strobes();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
